anim_sequencer: RTL
===================

Name: anim_sequencer

Overview:
Parametrised successor to the single-object VGA animation controller. It generates the frame-rate timebase and sequences INIT/ERASE/MOVE/DRAW passes over NUM_OBJ independent sprite channels. Per pass it drives one external drawer (finish handshake) and one mover (move strobe), selecting the active object via obj_sel. It sits between the datapath (position registers, pixel drawer) and the VGA adapter write port.

Parameters:
CLK_HZ, 50_000_000, system clock frequency.
FRAME_HZ, 60, frame tick rate. CLK_HZ/FRAME_HZ must be an integer of at least 2.
FRAMES_PER_STEP, 60, frame ticks per animation step (1..255).
NUM_OBJ, 4, number of sprite channels (1..16).
COLOR_W, 3, colour width.
BG_COLOUR, 0, colour used in ERASE.

Ports:
clk  in  1  system clock
resetn  in  1  synchronous reset, active-high, sampled on posedge clk
pause  in  1  high freezes the frame counter; the tick counter keeps running
finish  in  1  drawer done; single-cycle pulse or level, sampled only in INIT/ERASE/DRAW
obj_colour  in  COLOR_W  colour of the currently selected object (indexed by obj_sel)
obj_sel  out  OBJ_W=max(1,clog2(NUM_OBJ))  active object index
draw_color  out  COLOR_W  pixel colour to the adapter
wren  out  1  adapter write enable
init  out  1  datapath loads initial position for obj_sel
move  out  1  datapath advances position for obj_sel, one cycle
frame_tick  out  1  one-cycle pulse at FRAME_HZ
state  out  3  current FSM state, for debug and LEDs

Behaviour:
- Tick counter:
  - Loads CLK_HZ/FRAME_HZ-1 and decrements each cycle.
  - At 0 it reloads and frame_tick=1 for that cycle, giving a period of exactly CLK_HZ/FRAME_HZ cycles.
- Frame counter:
  - Loads FRAMES_PER_STEP-1 and decrements on frame_tick when pause=0.
  - On a tick at 0 it reloads and sets refresh_pend=1.
  - refresh_pend is sticky. It clears on the WAIT->ERASE transition.
  - If set and clear coincide, set wins.
- State encoding (package): INIT=0, ERASE=1, MOVE=2, DRAW=3, WAIT=4. Codes 5-7 go to INIT next cycle.
- Transitions:
  - INIT: finish -> obj_sel++. If obj_sel was NUM_OBJ-1, go to WAIT with obj_sel=0.
  - WAIT: refresh_pend -> ERASE with obj_sel=0.
  - ERASE: finish -> MOVE.
  - MOVE: always -> DRAW after one cycle.
  - DRAW: finish with obj_sel<NUM_OBJ-1 -> ERASE with obj_sel++. Finish with obj_sel=NUM_OBJ-1 -> WAIT with obj_sel=0.
- Outputs are Moore, decoded from registered state:
  - INIT: wren=1, init=1, draw_color=obj_colour.
  - ERASE: wren=1, draw_color=BG_COLOUR.
  - MOVE: move=1, draw_color=0.
  - DRAW: wren=1, draw_color=obj_colour.
  - WAIT: all zero.
- The state change on finish is visible the cycle after finish is sampled; there are no dead cycles.
- finish is ignored in MOVE/WAIT. finish held high in ERASE gives exactly one MOVE cycle.
- A refresh arriving mid-pass stays pending and starts the next pass immediately on entering WAIT. Further refreshes while pending are dropped.
- NUM_OBJ=1: obj_sel is constantly 0, and every DRAW finish goes to WAIT.
- Reset, including mid-pass:
  - Next cycle: state=INIT, obj_sel=0, both counters reloaded, refresh_pend=0, frame_tick=0.
  - Outputs are then INIT-decoded: wren=1, init=1, move=0, draw_color=obj_colour.
- The first animation step needs a full FRAMES_PER_STEP ticks after reset.

Optional Feature:
ANIM_OVERRUN_EN:
- Defined: adds output overrun_cnt [7:0]. It increments, saturating at 255, when refresh_pend would be set while already 1. Reset clears it to 0.
- Undefined: the port and logic are absent, and dropped refreshes are silent.

Decomposition:
- Package anim_pkg holds:
  - State localparams (INIT..WAIT) and the 3-bit state width.
  - The OBJ_W helper function.
- Sub-module frame_timer (generic, reused by other blocks):
  - Parameters CLK_HZ, FRAME_HZ, FRAMES_PER_STEP.
  - Inputs clk, resetn, pause.
  - Outputs frame_tick, step_pulse.
- The FSM stays in the top module.

Test Plan:
- Tick period, params CLK_HZ=600, FRAME_HZ=60, FRAMES_PER_STEP=2, NUM_OBJ=3. Release reset -> frame_tick every 10 cycles. refresh_pend set on the 2nd tick (cycle 20).
- INIT sweep. Pulse finish 3 times -> obj_sel 0,1,2 with init=1, wren=1. After the third, state=WAIT and obj_sel=0.
- Full pass. Refresh, then finish in each ERASE/DRAW -> sequence ERASE0 MOVE0 DRAW0 ERASE1 ... DRAW2 WAIT. move high exactly 3 single cycles. draw_color=BG_COLOUR in ERASE, obj_colour in DRAW.
- Refresh mid-pass. Hold finish low so DRAW1 stalls across a refresh -> after DRAW2 finish, WAIT lasts 1 cycle then ERASE0. With ANIM_OVERRUN_EN and two refreshes during the stall -> overrun_cnt=1.
- Pause. pause=1 across 5 ticks -> no refresh; resume -> refresh after 2 more ticks.
- Reset mid-ERASE, plus forced illegal state 6 -> next cycle INIT, obj_sel=0, wren=1, init=1. Illegal state recovers to INIT in 1 cycle.

Source files
------------

// File: rtl/anim_pkg.sv
// Purpose: shared state encoding and sizing helper for the animation sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package anim_pkg;

    localparam int STATE_W = 3;

    // Codes 5..7 are unused; the sequencer treats them as illegal and recovers to ST_INIT.
    typedef enum logic [STATE_W-1:0] {
        ST_INIT  = 3'd0,
        ST_ERASE = 3'd1,
        ST_MOVE  = 3'd2,
        ST_DRAW  = 3'd3,
        ST_WAIT  = 3'd4
    } anim_state_t;

    // Width of an object index; a single-object build still gets a 1-bit select.
    function automatic int obj_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Purpose: frame-rate tick generator plus a pausable frame counter that pulses once per animation step.
// Latency: frame_tick/step_pulse are combinational decodes of the registered counters (same cycle).
// Backpressure: none; pause freezes only the frame counter, the tick counter free-runs.
// Ports: clk, resetn (sync, active-high), pause in; frame_tick, step_pulse out.
module frame_timer #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int FRAME_HZ        = 60,
    parameter int FRAMES_PER_STEP = 60
) (
    input  logic clk,
    input  logic resetn,
    input  logic pause,
    output logic frame_tick,
    output logic step_pulse
);

    localparam int TICKS = CLK_HZ / FRAME_HZ;
    localparam int TW    = $clog2(TICKS);
    localparam int FW    = 8;

    localparam logic [TW-1:0] TICK_RELOAD  = TW'(TICKS - 1);
    localparam logic [FW-1:0] FRAME_RELOAD = FW'(FRAMES_PER_STEP - 1);

    logic [TW-1:0] tick_cnt;
    logic [FW-1:0] frame_cnt;

    // Period is exactly TICKS cycles: the reload cycle is also the tick cycle.
    assign frame_tick = (tick_cnt == '0);
    assign step_pulse = frame_tick && !pause && (frame_cnt == '0);

    always_ff @(posedge clk) begin
        if (resetn) begin
            tick_cnt <= TICK_RELOAD;
        end else if (frame_tick) begin
            tick_cnt <= TICK_RELOAD;
        end else begin
            tick_cnt <= tick_cnt - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            frame_cnt <= FRAME_RELOAD;
        end else if (frame_tick && !pause) begin
            if (frame_cnt == '0) begin
                frame_cnt <= FRAME_RELOAD;
            end else begin
                frame_cnt <= frame_cnt - FW'(1);
            end
        end
    end

endmodule

// File: rtl/anim_sequencer.sv
// Purpose: sequences INIT/ERASE/MOVE/DRAW passes over NUM_OBJ sprites at the animation step rate.
// Latency: Moore outputs from registered state; a sampled finish changes state on the next cycle.
// Backpressure: each ERASE/DRAW/INIT stalls until finish; refreshes arriving while one is pending are dropped.
// Ports: clk, resetn (sync, active-high), pause, finish, obj_colour in;
//        obj_sel, draw_color, wren, init, move, frame_tick, state out.
// Optional: define ANIM_OVERRUN_EN to add overrun_cnt[7:0], a saturating count of dropped refreshes.
module anim_sequencer
    import anim_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int FRAME_HZ        = 60,
    parameter int FRAMES_PER_STEP = 60,
    parameter int NUM_OBJ         = 4,
    parameter int COLOR_W         = 3,
    parameter int BG_COLOUR       = 0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          pause,
    input  logic                          finish,
    input  logic [COLOR_W-1:0]            obj_colour,
    output logic [obj_w(NUM_OBJ)-1:0]     obj_sel,
    output logic [COLOR_W-1:0]            draw_color,
    output logic                          wren,
    output logic                          init,
    output logic                          move,
    output logic                          frame_tick,
    output logic [STATE_W-1:0]            state
`ifdef ANIM_OVERRUN_EN
    ,
    output logic [7:0]                    overrun_cnt
`endif
);

    localparam int OBJ_W = obj_w(NUM_OBJ);
    localparam logic [OBJ_W-1:0]   LAST_OBJ = OBJ_W'(NUM_OBJ - 1);
    localparam logic [COLOR_W-1:0] BG       = COLOR_W'(BG_COLOUR);

    anim_state_t      state_q, state_d;
    logic [OBJ_W-1:0] obj_sel_q, obj_sel_d;
    logic             refresh_pend;
    logic             pend_clr;
    logic             step_pulse;

    frame_timer #(
        .CLK_HZ         (CLK_HZ),
        .FRAME_HZ       (FRAME_HZ),
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .pause     (pause),
        .frame_tick(frame_tick),
        .step_pulse(step_pulse)
    );

    // Sticky request; a new step arriving in the same cycle as the clear survives.
    always_ff @(posedge clk) begin
        if (resetn) begin
            refresh_pend <= 1'b0;
        end else if (step_pulse) begin
            refresh_pend <= 1'b1;
        end else if (pend_clr) begin
            refresh_pend <= 1'b0;
        end
    end

`ifdef ANIM_OVERRUN_EN
    // A step coinciding with the clear replaces a consumed request, so it is not a drop.
    always_ff @(posedge clk) begin
        if (resetn) begin
            overrun_cnt <= '0;
        end else if (step_pulse && refresh_pend && !pend_clr && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q   <= ST_INIT;
            obj_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            obj_sel_q <= obj_sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        obj_sel_d = obj_sel_q;
        pend_clr  = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (finish) begin
                    if (obj_sel_q == LAST_OBJ) begin
                        state_d   = ST_WAIT;
                        obj_sel_d = '0;
                    end else begin
                        obj_sel_d = obj_sel_q + OBJ_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (refresh_pend) begin
                    state_d   = ST_ERASE;
                    obj_sel_d = '0;
                    pend_clr  = 1'b1;
                end
            end
            ST_ERASE: begin
                if (finish) begin
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                if (finish) begin
                    if (obj_sel_q == LAST_OBJ) begin
                        state_d   = ST_WAIT;
                        obj_sel_d = '0;
                    end else begin
                        state_d   = ST_ERASE;
                        obj_sel_d = obj_sel_q + OBJ_W'(1);
                    end
                end
            end
            default: begin
                state_d   = ST_INIT;
                obj_sel_d = '0;
            end
        endcase
    end

    always_comb begin
        wren       = 1'b0;
        init       = 1'b0;
        move       = 1'b0;
        draw_color = '0;
        case (state_q)
            ST_INIT: begin
                wren       = 1'b1;
                init       = 1'b1;
                draw_color = obj_colour;
            end
            ST_ERASE: begin
                wren       = 1'b1;
                draw_color = BG;
            end
            ST_MOVE: begin
                move = 1'b1;
            end
            ST_DRAW: begin
                wren       = 1'b1;
                draw_color = obj_colour;
            end
            default: begin
            end
        endcase
    end

    assign obj_sel = obj_sel_q;
    assign state   = state_q;

endmodule
